muldiv_sched: RTL

//  Multi-cycle multiply/divide unit with its issue scheduler, in the E stage of the 5-stage MIPS pipeline.

---
 rtl/muldiv_sched_pkg.sv | 40 ++++
 rtl/muldiv_sched_core.sv | 69 ++++++
 rtl/muldiv_sched.sv | 118 +++++++++++
 3 files changed

// File: rtl/muldiv_sched_pkg.sv
// Shared types for the E-stage multiply/divide unit: HI/LO op codes, FSM states, latched request.
package muldiv_sched_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned MDOP_W = 4;

    typedef enum logic [MDOP_W-1:0] {
        MDOP_NONE  = 4'd0,
        MDOP_MULT  = 4'd1,
        MDOP_MULTU = 4'd2,
        MDOP_DIV   = 4'd3,
        MDOP_DIVU  = 4'd4,
        MDOP_MTHI  = 4'd5,
        MDOP_MTLO  = 4'd6,
        MDOP_MFHI  = 4'd7,
        MDOP_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    typedef struct packed {
        md_op_e          op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } md_req_t;

    // Ops that occupy the unit for a full countdown.
    function automatic logic is_muldiv(input logic [MDOP_W-1:0] op);
        return (op == MDOP_MULT) || (op == MDOP_MULTU) ||
               (op == MDOP_DIV)  || (op == MDOP_DIVU);
    endfunction

    function automatic logic is_div(input logic [MDOP_W-1:0] op);
        return (op == MDOP_DIV) || (op == MDOP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_sched_core.sv
// Combinational mult/div arithmetic; o_wr_en drops on divide-by-zero and on non-arithmetic ops.
module muldiv_sched_core
    import muldiv_sched_pkg::*;
(
    input  md_op_e            i_op,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    output logic [XLEN-1:0]   o_hi_n,
    output logic [XLEN-1:0]   o_lo_n,
    output logic              o_wr_en
);

    logic signed [2*XLEN-1:0] w_prod_s;
    logic        [2*XLEN-1:0] w_prod_u;
    logic signed [XLEN-1:0]   w_sa;
    logic signed [XLEN-1:0]   w_sb;
    logic signed [XLEN-1:0]   w_quo_s;
    logic signed [XLEN-1:0]   w_rem_s;
    logic        [XLEN-1:0]   w_quo_u;
    logic        [XLEN-1:0]   w_rem_u;
    logic                     w_b_zero;
    logic                     w_ovf;

    assign w_sa     = $signed(i_a);
    assign w_sb     = $signed(i_b);
    assign w_b_zero = (i_b == '0);
    // The only signed quotient that does not fit in 32 bits.
    assign w_ovf    = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

    assign w_prod_s = $signed({{XLEN{i_a[XLEN-1]}}, i_a}) * $signed({{XLEN{i_b[XLEN-1]}}, i_b});
    assign w_prod_u = {{XLEN{1'b0}}, i_a} * {{XLEN{1'b0}}, i_b};
    assign w_quo_s  = w_sa / w_sb;
    assign w_rem_s  = w_sa % w_sb;
    assign w_quo_u  = i_a / i_b;
    assign w_rem_u  = i_a % i_b;

    always_comb begin
        o_hi_n  = '0;
        o_lo_n  = '0;
        o_wr_en = 1'b0;
        case (i_op)
            MDOP_MULT: begin
                {o_hi_n, o_lo_n} = w_prod_s;
                o_wr_en          = 1'b1;
            end
            MDOP_MULTU: begin
                {o_hi_n, o_lo_n} = w_prod_u;
                o_wr_en          = 1'b1;
            end
            MDOP_DIV: begin
                o_wr_en = !w_b_zero;
                if (w_ovf) begin
                    o_lo_n = i_a;
                    o_hi_n = '0;
                end else begin
                    o_lo_n = w_quo_s;
                    o_hi_n = w_rem_s;
                end
            end
            MDOP_DIVU: begin
                o_wr_en = !w_b_zero;
                o_lo_n  = w_quo_u;
                o_hi_n  = w_rem_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv_sched.sv
// E-stage multiply/divide unit: owns HI/LO, models mult/div latency with a countdown, raises D-stage stall.
module muldiv_sched
    import muldiv_sched_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              md_valid,
    input  logic [MDOP_W-1:0] md_op,
    input  logic [XLEN-1:0]   rs_val,
    input  logic [XLEN-1:0]   rt_val,
    input  logic              d_is_md,
    output logic              busy,
    output logic              md_stall,
    output logic [XLEN-1:0]   md_rdata,
    output logic [XLEN-1:0]   hi,
    output logic [XLEN-1:0]   lo
);

    localparam int unsigned CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    md_state_e          r_state;
    md_state_e          w_state_n;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_n;
    md_req_t            r_req;
    md_req_t            w_req_n;
    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    w_hi_n;
    logic [XLEN-1:0]    r_lo;
    logic [XLEN-1:0]    w_lo_n;

    logic               w_start;
    logic [XLEN-1:0]    w_res_hi;
    logic [XLEN-1:0]    w_res_lo;
    logic               w_res_wr;

    assign w_start = md_valid && is_muldiv(md_op) && (r_state == ST_IDLE);

    // Result always comes from the operands latched at start, not the live ports.
    muldiv_sched_core u_core (
        .i_op    (r_req.op),
        .i_a     (r_req.a),
        .i_b     (r_req.b),
        .o_hi_n  (w_res_hi),
        .o_lo_n  (w_res_lo),
        .o_wr_en (w_res_wr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_req   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_req   <= w_req_n;
            r_hi    <= w_hi_n;
            r_lo    <= w_lo_n;
        end
    end

    // Next-state: ops arriving while busy fall through with no effect.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_req_n   = r_req;
        w_hi_n    = r_hi;
        w_lo_n    = r_lo;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_n = ST_BUSY;
                    w_req_n   = '{op: md_op_e'(md_op), a: rs_val, b: rt_val};
                    w_cnt_n   = is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                end else if (md_valid && (md_op == MDOP_MTHI)) begin
                    w_hi_n = rs_val;
                end else if (md_valid && (md_op == MDOP_MTLO)) begin
                    w_lo_n = rs_val;
                end
            end
            ST_BUSY: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_n = ST_IDLE;
                    w_cnt_n   = '0;
                    if (w_res_wr) begin
                        w_hi_n = w_res_hi;
                        w_lo_n = w_res_lo;
                    end
                end else begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        md_rdata = '0;
        if (md_valid && (md_op == MDOP_MFHI)) begin
            md_rdata = r_hi;
        end else if (md_valid && (md_op == MDOP_MFLO)) begin
            md_rdata = r_lo;
        end
    end

    assign md_stall = d_is_md && ((r_state == ST_BUSY) || w_start);
    assign busy     = (r_state == ST_BUSY);
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
